// File: rtl/line_buffer_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// line_buffer_ctrl_if : pixel-in, line-buffer and window-out signals of the
//                       line buffer sequencer (master = controller side)
// Rev 1.0
// ============================================================================
interface line_buffer_ctrl_if #(
  parameter int M = 3,
  parameter int W = 512,
  parameter int N = 4
);
  logic [7:0]           i_pix;
  logic                 i_pix_valid;
  logic                 o_pix_ready;
  logic [7:0]           o_lb_data;
  logic                 o_lb_data_valid;
  logic                 o_lb_rd_data;
  logic [M*N*8-1:0]     i_lb_data;
  logic [M*N*8-1:0]     o_win;
  logic                 o_win_valid;
  logic                 i_win_ready;
  logic [$clog2(W)-1:0] o_win_idx;

  modport master (
    input  i_pix, i_pix_valid, i_lb_data, i_win_ready,
    output o_pix_ready, o_lb_data, o_lb_data_valid, o_lb_rd_data,
           o_win, o_win_valid, o_win_idx
  );

  modport slave (
    output i_pix, i_pix_valid, i_lb_data, i_win_ready,
    input  o_pix_ready, o_lb_data, o_lb_data_valid, o_lb_rd_data,
           o_win, o_win_valid, o_win_idx
  );
endinterface
`default_nettype wire

// File: rtl/line_buffer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// line_buffer_ctrl : fills the line buffer with M*W pixels, then strobes out
//                    one n-wide M-channel window per position with valid/ready
// Rev 1.0
// ============================================================================
module line_buffer_ctrl #(
  parameter int M = 3,
  parameter int W = 512,
  parameter int N = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  line_buffer_ctrl_if.master bus
);
  localparam int WR_W  = $clog2(M*W+1);
  localparam int RD_W  = $clog2(W+1);
  localparam int IDX_W = $clog2(W);
  localparam logic [WR_W-1:0]  WR_END   = WR_W'(M*W);
  localparam logic [RD_W-1:0]  RD_END   = RD_W'(W-N+1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W-N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WR_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [RD_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [7:0]       lb_data_q, lb_data_d;
  logic             lb_data_valid_q, lb_data_valid_d;
  logic             win_valid_q, win_valid_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;

  logic pix_ready;
  logic pix_accept;
  logic win_accept;
  logic rd_strobe;

  always_comb begin
    // Ready stays high through the last accept; the count itself closes it.
    pix_ready  = (state_q == S_FILL) && (wr_cnt_q < WR_END);
    pix_accept = pix_ready && bus.i_pix_valid;
    win_accept = win_valid_q && bus.i_win_ready;
    rd_strobe  = (state_q == S_READ) && (rd_cnt_q < RD_END) &&
                 (!win_valid_q || bus.i_win_ready);

    state_d         = state_q;
    wr_cnt_d        = wr_cnt_q;
    rd_cnt_d        = rd_cnt_q;
    win_valid_d     = win_valid_q;
    win_idx_d       = win_idx_q;
    lb_data_valid_d = pix_accept;
    lb_data_d       = pix_accept ? bus.i_pix : lb_data_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_FILL;
      end
      S_FILL: begin
        if (pix_accept) wr_cnt_d = wr_cnt_q + WR_W'(1);
        // Wait one cycle after the final write so it lands before the first read.
        if (wr_cnt_q == WR_END) state_d = S_READ;
      end
      S_READ: begin
        if (rd_strobe) begin
          rd_cnt_d    = rd_cnt_q + RD_W'(1);
          win_valid_d = 1'b1;
          win_idx_d   = rd_cnt_q[IDX_W-1:0];
        end else if (win_accept) begin
          win_valid_d = 1'b0;
        end
        if (win_accept && (win_idx_q == IDX_LAST)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d     = S_IDLE;
        wr_cnt_d    = '0;
        rd_cnt_d    = '0;
        win_idx_d   = '0;
        win_valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= S_IDLE;
      wr_cnt_q        <= '0;
      rd_cnt_q        <= '0;
      lb_data_q       <= '0;
      lb_data_valid_q <= 1'b0;
      win_valid_q     <= 1'b0;
      win_idx_q       <= '0;
    end else begin
      state_q         <= state_d;
      wr_cnt_q        <= wr_cnt_d;
      rd_cnt_q        <= rd_cnt_d;
      lb_data_q       <= lb_data_d;
      lb_data_valid_q <= lb_data_valid_d;
      win_valid_q     <= win_valid_d;
      win_idx_q       <= win_idx_d;
    end
  end

  assign bus.o_pix_ready     = pix_ready;
  assign bus.o_lb_data       = lb_data_q;
  assign bus.o_lb_data_valid = lb_data_valid_q;
  assign bus.o_lb_rd_data    = rd_strobe;
  // The line buffer holds its output between strobes, so a stalled window stays put.
  assign bus.o_win           = bus.i_lb_data;
  assign bus.o_win_valid     = win_valid_q;
  assign bus.o_win_idx       = win_idx_q;
  assign o_busy              = (state_q != S_IDLE);
  assign o_done              = (state_q == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_line_buffer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for line_buffer_ctrl: line-buffer model plus write/window scoreboards.
module tb_line_buffer_ctrl;
  localparam int M     = 3;
  localparam int W     = 512;
  localparam int N     = 4;
  localparam int NWIN  = W - N + 1;
  localparam int IDX_W = $clog2(W);
  localparam int WB    = M * N * 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;

  line_buffer_ctrl_if #(.M(M), .W(W), .N(N)) bus ();

  line_buffer_ctrl #(.M(M), .W(W), .N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Line buffer model: stores writes in order, registers a window per read strobe.
  logic [7:0]    mem [M*W];
  logic [WB-1:0] lb_out;
  int            wp, rp;
  assign bus.i_lb_data = lb_out;

  function automatic logic [WB-1:0] mem_window(input int k);
    logic [WB-1:0] w = '0;
    for (int c = 0; c < M; c++)
      for (int j = 0; j < N; j++)
        w[(M*N-1-(c*N+j))*8 +: 8] = mem[c*W + k + j];
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_out <= '0;
      wp     <= 0;
      rp     <= 0;
    end else if (start && !busy) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (bus.o_lb_data_valid && wp < M*W) begin
        mem[wp] <= bus.o_lb_data;
        wp      <= wp + 1;
      end
      if (bus.o_lb_rd_data && rp < NWIN) begin
        lb_out <= mem_window(rp);
        rp     <= rp + 1;
      end
    end
  end

  // Scoreboard state
  logic [7:0]    exp_line [M*W];
  logic [7:0]    pix_q [$];
  int            idx_q [$];
  logic [WB-1:0] win_q [$];
  int tb_wr, n_writes, tb_rd, n_acc, cyc, first_strobe_cyc, last_acc_cyc;

  function automatic logic [WB-1:0] exp_window(input int k);
    logic [WB-1:0] w = '0;
    for (int c = 0; c < M; c++)
      for (int j = 0; j < N; j++)
        w[(M*N-1-(c*N+j))*8 +: 8] = exp_line[c*W + k + j];
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample on the falling edge and run the scoreboards for the coming rising edge.
  task automatic sample();
    logic [7:0]    ep;
    int            ei;
    logic [WB-1:0] ew;
    @(negedge clk);
    cyc++;
    if (!rst_n || (start && !busy)) begin
      pix_q.delete(); idx_q.delete(); win_q.delete();
      tb_wr = 0; n_writes = 0; tb_rd = 0; n_acc = 0;
    end else begin
      if (bus.o_lb_data_valid) begin
        n_writes++;
        total++;
        if (pix_q.size() == 0) begin
          bad++;
          $display("FAIL lb_write: unexpected write data=%0h, expected no write", bus.o_lb_data);
        end else begin
          ep = pix_q.pop_front();
          if (bus.o_lb_data !== ep) begin
            bad++;
            $display("FAIL lb_data: write %0d got %0h expected %0h", n_writes-1, bus.o_lb_data, ep);
          end
        end
      end
      if (bus.i_pix_valid && bus.o_pix_ready) begin
        total++;
        if (tb_wr >= M*W) begin
          bad++;
          $display("FAIL pix_accept: accept %0d beyond fill size %0d", tb_wr, M*W);
        end else begin
          exp_line[tb_wr] = bus.i_pix;
        end
        pix_q.push_back(bus.i_pix);
        tb_wr++;
      end
      if (bus.o_win_valid && bus.i_win_ready) begin
        total++;
        if (idx_q.size() == 0) begin
          bad++;
          $display("FAIL win_accept: unexpected window idx=%0d", bus.o_win_idx);
        end else begin
          ei = idx_q.pop_front();
          ew = win_q.pop_front();
          if (bus.o_win_idx !== IDX_W'(ei) || bus.o_win !== ew) begin
            bad++;
            $display("FAIL window: got idx=%0d win=%h expected idx=%0d win=%h",
                     bus.o_win_idx, bus.o_win, ei, ew);
          end
          if (ei == NWIN-1) last_acc_cyc = cyc;
        end
        n_acc++;
      end
      if (bus.o_lb_rd_data) begin
        total++;
        if ((bus.o_win_valid && !bus.i_win_ready) || tb_rd >= NWIN) begin
          bad++;
          $display("FAIL rd_strobe: strobe %0d while valid=%0b ready=%0b, expected none",
                   tb_rd, bus.o_win_valid, bus.i_win_ready);
        end else begin
          if (tb_rd == 0) first_strobe_cyc = cyc;
          idx_q.push_back(tb_rd);
          win_q.push_back(exp_window(tb_rd));
        end
        tb_rd++;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    rst_n = 1'b0; start = 1'b1;
    bus.i_pix_valid = 1'b1; bus.i_pix = 8'h5A; bus.i_win_ready = 1'b1;
    repeat (3) begin
      sample();
      outs = {busy, done, bus.o_pix_ready, bus.o_lb_data_valid, bus.o_lb_rd_data,
              bus.o_win_valid, 9'(bus.o_win_idx), bus.o_lb_data, 9'd0};
      total++;
      if (outs !== 32'd0 || bus.o_win !== '0) begin
        bad++;
        $display("FAIL reset_outputs: got %h win=%h expected all zero", outs, bus.o_win);
      end
    end
    start = 1'b0; bus.i_pix_valid = 1'b0; rst_n = 1'b1;
    sample();
    total++;
    if (busy !== 1'b0 || bus.o_pix_ready !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle: got busy=%0b ready=%0b expected 0 0", busy, bus.o_pix_ready);
    end
  endtask

  task automatic test_fill(input bit gaps, input bit rnd, input bit pix_with_start);
    int k = 0;
    int guard = 0;
    bit acc;
    bit v = 1'b1;
    step();
    start = 1'b1; bus.i_pix_valid = pix_with_start; bus.i_pix = 8'hAA;
    sample();
    total++;
    if (bus.o_pix_ready !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL start_cycle: got ready=%0b busy=%0b expected 0 0", bus.o_pix_ready, busy);
    end
    step();
    start = 1'b0;
    bus.i_pix_valid = 1'b1;
    bus.i_pix = rnd ? 8'($urandom_range(0, 255)) : 8'(k);
    while (k < M*W && guard < 4*M*W) begin
      sample();
      acc = bus.i_pix_valid && bus.o_pix_ready;
      step();
      guard++;
      if (acc) k++;
      if (gaps) v = !v;
      start = (k == 700);  // must be ignored while busy
      bus.i_pix_valid = (k < M*W) ? v : 1'b1;
      bus.i_pix = rnd ? 8'($urandom_range(0, 255)) : 8'(k);
    end
    start = 1'b0;
    bus.i_pix_valid = 1'b1;  // keep offering; nothing more may be taken
    total++;
    if (k != M*W) begin
      bad++;
      $display("FAIL fill_timeout: accepted %0d expected %0d", k, M*W);
    end
    sample();
    total++;
    if ({bus.o_pix_ready, bus.o_lb_data_valid, busy} !== 3'b011) begin
      bad++;
      $display("FAIL fill_end: got ready/wvalid/busy=%b expected 011",
               {bus.o_pix_ready, bus.o_lb_data_valid, busy});
    end
    sample();
    total++;
    if (bus.o_lb_rd_data !== 1'b1 || n_writes != M*W || tb_wr != M*W) begin
      bad++;
      $display("FAIL read_entry: got strobe=%0b writes=%0d accepts=%0d expected 1 %0d %0d",
               bus.o_lb_rd_data, n_writes, tb_wr, M*W, M*W);
    end
  endtask

  task automatic test_read(input bit bp);
    int guard = 0;
    logic [WB-1:0] held;
    if (bp) begin
      while (!(bus.o_win_valid && bus.o_win_idx == IDX_W'(9)) && guard < 100) begin
        sample();
        guard++;
      end
      step();
      bus.i_win_ready = 1'b0;
      held = exp_window(10);
      repeat (5) begin
        sample();
        total++;
        if (bus.o_win_valid !== 1'b1 || bus.o_win_idx !== IDX_W'(10) ||
            bus.o_lb_rd_data !== 1'b0 || bus.o_win !== held) begin
          bad++;
          $display("FAIL bp_hold: got valid=%0b idx=%0d strobe=%0b win=%h expected 1 10 0 %h",
                   bus.o_win_valid, bus.o_win_idx, bus.o_lb_rd_data, bus.o_win, held);
        end
        step();
      end
      bus.i_win_ready = 1'b1;
      sample();
      total++;
      if (bus.o_lb_rd_data !== 1'b1) begin
        bad++;
        $display("FAIL bp_resume: got strobe=%0b expected 1", bus.o_lb_rd_data);
      end
      sample();
      total++;
      if (bus.o_win_valid !== 1'b1 || bus.o_win_idx !== IDX_W'(11)) begin
        bad++;
        $display("FAIL bp_next: got valid=%0b idx=%0d expected 1 11", bus.o_win_valid, bus.o_win_idx);
      end
    end
    guard = 0;
    while (!done && guard < 2000) begin
      sample();
      guard++;
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b1 || n_acc != NWIN || tb_rd != NWIN || cyc - last_acc_cyc != 1) begin
      bad++;
      $display("FAIL done_pulse: got done=%0b busy=%0b acc=%0d strobes=%0d lag=%0d expected 1 1 %0d %0d 1",
               done, busy, n_acc, tb_rd, cyc - last_acc_cyc, NWIN, NWIN);
    end
    if (!bp) begin
      total++;
      if (last_acc_cyc - first_strobe_cyc != NWIN) begin
        bad++;
        $display("FAIL full_rate: got %0d cycles expected %0d", last_acc_cyc - first_strobe_cyc, NWIN);
      end
    end
    sample();
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || bus.o_win_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_done: got done=%0b busy=%0b valid=%0b expected 0 0 0",
               done, busy, bus.o_win_valid);
    end
  endtask

  task automatic test_abort();
    int guard = 0;
    logic [31:0] outs;
    test_fill(1'b0, 1'b1, 1'b0);
    while (!(bus.o_win_valid && bus.o_win_idx == IDX_W'(200)) && guard < 1000) begin
      sample();
      guard++;
    end
    total++;
    if (guard >= 1000) begin
      bad++;
      $display("FAIL abort_reach: got idx=%0d expected 200", bus.o_win_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {busy, done, bus.o_pix_ready, bus.o_lb_data_valid, bus.o_lb_rd_data,
            bus.o_win_valid, 9'(bus.o_win_idx), bus.o_lb_data, 9'd0};
    total++;
    if (outs !== 32'd0) begin
      bad++;
      $display("FAIL abort_clear: got %h expected all zero", outs);
    end
    sample();
    step();
    rst_n = 1'b1;
    sample();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_idle: got busy=%0b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    bus.i_win_ready = 1'b1;
    test_fill(1'b0, 1'b0, 1'b0);
    test_read(1'b1);
    test_fill(1'b1, 1'b1, 1'b0);
    test_read(1'b0);
    test_abort();
    test_fill(1'b0, 1'b0, 1'b1);
    test_read(1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
